// File: rtl/multimode_counter.sv
// multimode_counter: up/down counter with load, wrap or saturate at the
// bounds 0..MAX_VALUE, a registered terminal-count pulse and a zero flag.
// Optional prescaler compiled in with MULTIMODE_COUNTER_PRESCALE_EN; when it
// is absent every enabled, non-load edge is a step and PRESCALE is unused.
module multimode_counter #(
  parameter int WIDTH     = 5,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_w,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] w_output,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  // Reject out-of-range parameters at elaboration.
  if (PRESCALE < 2 || MAX_VALUE < 1 || MAX_VALUE > 2**WIDTH-1) begin : g_param_check
    $error("multimode_counter: illegal PRESCALE or MAX_VALUE");
  end

  logic [WIDTH-1:0] load_clamped;
  logic             step;
  logic             at_bound;

  // A full-range counter needs no clamp; skipping it avoids a constant compare.
  if (MAX_VALUE >= 2**WIDTH-1) begin : g_no_clamp
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  end

`ifdef MULTIMODE_COUNTER_PRESCALE_EN
  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE-1);

  logic [PW-1:0] pre_cnt;

  // Prescaler: counts enabled edges, cleared by load, wraps after the step edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (load_w) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (pre_cnt == PS_LAST) pre_cnt <= '0;
      else                    pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign step = en && !load_w && (pre_cnt == PS_LAST);
`else
  assign step = en && !load_w;
`endif

  assign at_bound = up_dn ? (w_output == MAX_V) : (w_output == '0);

  // Count register and terminal-count pulse; load wins over a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_output <= '0;
      tc       <= 1'b0;
    end else if (load_w) begin
      w_output <= load_clamped;
      tc       <= 1'b0;
    end else if (step) begin
      tc <= at_bound;
      if (up_dn) begin
        if (!at_bound)     w_output <= w_output + WIDTH'(1);
        else if (!sat_mode) w_output <= '0;
      end else begin
        if (!at_bound)     w_output <= w_output - WIDTH'(1);
        else if (!sat_mode) w_output <= MAX_V;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  // Zero flag follows the register directly, so it asserts during reset.
  assign zero = (w_output == '0);

endmodule

// File: tb/tb_multimode_counter.sv
// Randomized plus directed bench for multimode_counter: a full-range instance
// (MAX_VALUE=31) and a MAX_VALUE=9 instance share stimulus and are checked
// against a behavioural model on every edge.
module tb_multimode_counter;

`ifdef MULTIMODE_COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam int MAX_A = 31;
  localparam int MAX_B = 9;

  logic       clk = 1'b0;
  logic       reset, load_w, en, up_dn, sat_mode;
  logic [4:0] load_val;
  logic [4:0] wa, wb;
  logic       tca, tcb, za, zb;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int ca, cb, en_run;
  bit ta, tb;

  multimode_counter #(.WIDTH(5), .MAX_VALUE(MAX_A), .PRESCALE(4)) dut_a (
    .clk(clk), .reset(reset), .load_w(load_w), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .w_output(wa), .tc(tca), .zero(za));

  multimode_counter #(.WIDTH(5), .MAX_VALUE(MAX_B), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .load_w(load_w), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .w_output(wb), .tc(tcb), .zero(zb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ca = 0; cb = 0; en_run = 0; ta = 0; tb = 0;
  endtask

  // One bounded counter step; returns whether it was taken from a bound.
  task automatic step_one(input int maxv, inout int c, output bit t);
    t = 0;
    if (up_dn) begin
      if (c == maxv) begin t = 1; c = sat_mode ? maxv : 0; end
      else c = c + 1;
    end else begin
      if (c == 0) begin t = 1; c = sat_mode ? 0 : maxv; end
      else c = c - 1;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (load_w) begin
      ca = (load_val > MAX_A) ? MAX_A : int'(load_val);
      cb = (load_val > MAX_B) ? MAX_B : int'(load_val);
      en_run = 0; ta = 0; tb = 0;
    end else if (en) begin
      en_run++;
      if (en_run % PS == 0) begin
        step_one(MAX_A, ca, ta);
        step_one(MAX_B, cb, tb);
      end else begin
        ta = 0; tb = 0;
      end
    end else begin
      ta = 0; tb = 0;
    end
  endtask

  task automatic check_all();
    chk("a_w", wa, ca);  chk("a_tc", tca, ta);  chk("a_zero", za, ca == 0);
    chk("b_w", wb, cb);  chk("b_tc", tcb, tb);  chk("b_zero", zb, cb == 0);
  endtask

  // Inputs change after the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed between edges (called just after negedge).
  task automatic async_reset();
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    #1 reset = 1'b1;
  endtask

  int sat_exp[5] = '{8, 9, 9, 9, 9};
  int sat_tc[5]  = '{0, 0, 1, 1, 1};

  initial begin
    reset = 1'b0; load_w = 0; load_val = '0; en = 0; up_dn = 1; sat_mode = 0;
    model_reset();
    @(negedge clk);

    // reset held over three edges, then released with en=0
    repeat (3) tick();
    chk("rst_w", wa, 0); chk("rst_tc", tca, 0); chk("rst_zero", za, 1);
    reset = 1'b1;
    repeat (3) tick();
    chk("hold_w", wa, 0); chk("hold_zero", za, 1);

    // full-range wrap
    en = 1; up_dn = 1; sat_mode = 0;
    repeat (31*PS) tick();
    chk("wrap_31", wa, 31); chk("wrap_31_tc", tca, 0);
    repeat (PS) tick();
    chk("wrap_0", wa, 0); chk("wrap_0_tc", tca, 1);
    tick();
    chk("wrap_tc_clear", tca, 0);

    // saturation on the MAX_VALUE=9 instance
    en = 0; load_w = 1; load_val = 5'd7;
    tick();
    chk("load_7", wb, 7);
    load_w = 0; en = 1; sat_mode = 1; up_dn = 1;
    for (int k = 0; k < 5; k++) begin
      repeat (PS) tick();
      chk("sat_w", wb, sat_exp[k]);
      chk("sat_tc", tcb, sat_tc[k]);
    end

    // down count with wrap, then clamped load taking priority over en
    en = 0; load_w = 1; load_val = 5'd1;
    tick();
    load_w = 0; en = 1; sat_mode = 0; up_dn = 0;
    repeat (PS) tick();
    chk("down_0", wb, 0); chk("down_0_zero", zb, 1);
    repeat (PS) tick();
    chk("down_wrap_9", wb, 9); chk("down_wrap_tc", tcb, 1);
    load_w = 1; load_val = 5'd20;
    tick();
    chk("load_clamp", wb, 9); chk("load_no_tc", tcb, 0); chk("load_a_20", wa, 20);
    load_w = 0;

`ifdef MULTIMODE_COUNTER_PRESCALE_EN
    // prescale spacing and restart from a load
    en = 0; async_reset();
    en = 1; up_dn = 1; sat_mode = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) chk("ps_e3", wa, 0);
      if (e == 4) chk("ps_e4", wa, 1);
      if (e == 8) chk("ps_e8", wa, 2);
    end
    en = 0; async_reset();
    en = 1;
    for (int e = 1; e <= 10; e++) begin
      load_w = (e == 6); load_val = 5'd0;
      tick();
      if (e == 6)  chk("ps_load", wa, 0);
      if (e == 9)  chk("ps_after_load_e9", wa, 0);
      if (e == 10) chk("ps_after_load_e10", wa, 1);
    end
    load_w = 0;
`endif

    // async reset mid-count at 13
    en = 0; load_w = 1; load_val = 5'd13;
    tick();
    chk("pre_async_13", wa, 13);
    load_w = 0;
    #1 reset = 1'b0;
    #1 chk("async_w", wa, 0); chk("async_zero", za, 1); chk("async_tc", tca, 0);
    model_reset();
    #1 reset = 1'b1;
    en = 1; up_dn = 1; sat_mode = 0;
    repeat (PS) tick();
    chk("restart_1", wa, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      load_w   = ($urandom_range(7) == 0);
      load_val = 5'($urandom);
      en       = ($urandom_range(3) != 0);
      up_dn    = 1'($urandom);
      sat_mode = 1'($urandom);
      if ($urandom_range(99) == 0) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 5, giving the counter and data width in bits.
REQ-002 SHALL provide parameter MAX_VALUE, default 2**WIDTH-1, giving the upper count bound (legal range 1 to 2**WIDTH-1).
REQ-003 SHALL provide parameter PRESCALE, default 4, giving the enable cycles per step when prescaling is compiled in (legal range 2 or more).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL provide port load_w, input, 1 bit: synchronous load request.
REQ-007 SHALL provide port load_val, input, WIDTH bits: value loaded when load_w=1.
REQ-008 SHALL provide port en, input, 1 bit: count enable.
REQ-009 SHALL provide port up_dn, input, 1 bit: 1 counts up, 0 counts down.
REQ-010 SHALL provide port sat_mode, input, 1 bit: 1 saturates at the bounds, 0 wraps.
REQ-011 SHALL provide port w_output, output, WIDTH bits: registered count value.
REQ-012 SHALL provide port tc, output, 1 bit: registered terminal-count pulse.
REQ-013 SHALL provide port zero, output, 1 bit: combinational flag, 1 exactly when w_output==0.

Function
REQ-014 SHALL give load_w priority over en; on a load edge w_output = min(load_val, MAX_VALUE) and no step occurs.
REQ-015 SHALL perform a step on an edge where load_w=0 and the step condition holds (REQ-024/REQ-025); otherwise w_output holds.
REQ-016 SHALL, on an up step below MAX_VALUE, increment by 1; on a down step above 0, decrement by 1.
REQ-017 SHALL, on an up step at MAX_VALUE, go to 0 when sat_mode=0 and hold MAX_VALUE when sat_mode=1.
REQ-018 SHALL, on a down step at 0, go to MAX_VALUE when sat_mode=0 and hold 0 when sat_mode=1.
REQ-019 SHALL set tc=1 for exactly one cycle after any step taken from a bound (up at MAX_VALUE, or down at 0), regardless of sat_mode; tc=0 otherwise.
REQ-020 SHALL sample up_dn and sat_mode every edge; a direction change takes effect on the next step, with no pipeline lag.
REQ-021 SHALL keep w_output within 0..MAX_VALUE at all times after reset.

Reset
REQ-022 SHALL, while reset=0, immediately force w_output=0, tc=0 and the prescaler to 0, independent of clk; zero=1.
REQ-023 SHALL resume normal operation on the first rising clk edge after reset returns to 1; a reset in mid-count discards the count and any pending prescale progress.

Configuration
REQ-024 SHALL, when macro MULTIMODE_COUNTER_PRESCALE_EN is defined, include a prescaler of ceil(log2(PRESCALE)) bits:
- increments on each en=1, load_w=0 edge;
- a step occurs only on the edge where the prescaler equals PRESCALE-1 and en=1, and the prescaler then returns to 0;
- load_w=1 clears the prescaler;
- en=0 holds the prescaler.
REQ-025 SHALL, when MULTIMODE_COUNTER_PRESCALE_EN is undefined, contain no prescaler logic; every en=1, load_w=0 edge is a step, and PRESCALE is ignored.

Verification
REQ-026 SHALL check reset at defaults: hold reset=0 across 3 edges -> w_output=0, tc=0, zero=1; release, en=0 -> values hold.
REQ-027 SHALL check up-count wrap (no prescale, WIDTH=5, MAX_VALUE=31, sat_mode=0, up_dn=1, en=1):
- from 0, w_output is 31 after 31 edges and 0 after 32 edges;
- tc=1 for only the cycle after the 31->0 step.
REQ-028 SHALL check saturation with MAX_VALUE=9, sat_mode=1:
- load_val=7 loads 7;
- 5 up steps give 8, 9, 9, 9, 9;
- tc pulses after each step taken at 9.
REQ-029 SHALL check down-count and load priority with MAX_VALUE=9, sat_mode=0, up_dn=0:
- from 1, two steps give 0 then 9, with zero=1 at 0;
- load_w=1 with en=1 and load_val=20 gives w_output=9 (clamped), with no step.
REQ-030 SHALL check prescale with the macro defined, PRESCALE=4, en=1, up:
- from 0, w_output=1 after edge 4 and 2 after edge 8;
- load_w on edge 6 restarts the 4-edge spacing from that load.
REQ-031 SHALL check asynchronous reset mid-count: assert reset=0 between edges at w_output=13 -> w_output=0 before the next clk edge, and the count restarts from 0.
